// File: rtl/rat_pkg.sv
// Shared RAT CPU definitions: datapath widths, PC mux selects and stack op decode.
package rat_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 32;

  // Interrupt service routine entry address.
  localparam logic [PC_WIDTH-1:0] PC_INTR_VECTOR = 10'h3FF;

  typedef enum logic [1:0] {
    PC_SEL_IMMED = 2'd0,
    PC_SEL_STACK = 2'd1,
    PC_SEL_INTR  = 2'd2
  } pc_mux_sel_t;

  // Return-stack operation requested by the {push, pop} strobe pair.
  typedef enum logic [1:0] {
    STACK_OP_NONE    = 2'b00,
    STACK_OP_POP     = 2'b01,
    STACK_OP_PUSH    = 2'b10,
    STACK_OP_REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_stack_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Return-stack storage: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on a write strobe.
  // NOTE: the array has no reset; entries above SP are never observable, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware call/return stack. TOS is held in a register so the PC mux sees a
// clean value the cycle after any operation; the RAM holds everything below it.
module return_stack
  import rat_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_WIDTH-1:0]    din,
  output logic [ADDR_WIDTH-1:0]    from_stack,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  stack_op_t             op;
  logic [SPW-1:0]        sp_next;
  logic [ADDR_WIDTH-1:0] tos_next;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [AW-1:0]         ram_raddr;
  logic [ADDR_WIDTH-1:0] ram_rdata;

  assign op    = decode_stack_op(push, pop);
  assign empty = (sp == '0);
  assign full  = (sp == SP_FULL);

  // The entry that becomes TOS after a pop sits two below SP; modulo-DEPTH
  // arithmetic on the low bits also covers SP == DEPTH.
  assign ram_raddr = sp[AW-1:0] - AW'(2);

  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (din),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state decode for SP, TOS, RAM write and the sticky error flags.
  // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    sp_next   = sp;
    tos_next  = from_stack;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = sp[AW-1:0];
    unique case (op)
      STACK_OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          ram_we   = 1'b1;
          tos_next = din;
          sp_next  = sp + SPW'(1);
        end
      end
      STACK_OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else if (sp == SPW'(1)) begin
          sp_next  = '0;
          tos_next = '0;
        end else begin
          sp_next  = sp - SPW'(1);
          tos_next = ram_rdata;
        end
      end
      STACK_OP_REPLACE: begin
        ram_we   = 1'b1;
        tos_next = din;
        if (empty) begin
          // Nothing to replace: behave as a plain push but record the bad pop.
          unf_set = 1'b1;
          sp_next = SPW'(1);
        end else begin
          ram_waddr = sp[AW-1:0] - AW'(1);
        end
      end
      default: ;
    endcase
  end

  // State register: SP, TOS and the sticky flags; reset wins over any op.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp         <= '0;
      from_stack <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      sp         <= sp_next;
      from_stack <= tos_next;
      overflow   <= overflow | ovf_set;
      underflow  <= underflow | unf_set;
    end
  end

endmodule
